// File: rtl/congestion_scheduler.sv
// Pseudo-random back-pressure injector for NUM_CH valid/ready channels.
// A shared Galois LFSR drives per-channel OPEN/STALL FSMs; no data is ever stored.
module congestion_scheduler #(
    parameter int unsigned NUM_CH    = 4,
    parameter logic [15:0] SEED      = 16'hACE1,
    parameter int unsigned MAX_BURST = 15,
    localparam int unsigned BW       = $clog2(MAX_BURST + 1)
) (
    input  logic              clk_i,
    input  logic              rst_ni,
    input  logic              cfg_en_i,
    input  logic [6:0]        cfg_level_i,
    input  logic [BW-1:0]     cfg_burst_i,
    input  logic [NUM_CH-1:0] valid_i,
    output logic [NUM_CH-1:0] ready_o,
    output logic [NUM_CH-1:0] valid_o,
    input  logic [NUM_CH-1:0] ready_i,
    output logic [31:0]       stall_cnt_o
);

    localparam logic [15:0] LFSR_INIT = (SEED == 16'h0000) ? 16'h0001 : SEED;
    localparam int unsigned PW        = $clog2(NUM_CH + 1);

    typedef enum logic {
        ST_OPEN,
        ST_STALL
    } ch_state_e;

    logic [15:0]       lfsr_q;
    logic [15:0]       lfsr_d;
    logic [6:0]        level_clamped;
    logic [BW-1:0]     burst_load;
    logic [NUM_CH-1:0] stalled;
    logic [PW-1:0]     stall_pop;
    logic [32:0]       stall_sum;
    logic [31:0]       stall_cnt_q;
    logic [31:0]       stall_cnt_d;

    // Right-shifting Galois form of x^16+x^14+x^13+x^11+1.
    assign lfsr_d = {1'b0, lfsr_q[15:1]} ^ (lfsr_q[0] ? 16'hB400 : 16'h0000);

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            lfsr_q <= LFSR_INIT;
        end else begin
            lfsr_q <= lfsr_d;
        end
    end

    assign level_clamped = (cfg_level_i > 7'd100) ? 7'd100 : cfg_level_i;
    assign burst_load    = (cfg_burst_i == '0) ? BW'(1) : cfg_burst_i;

    for (genvar c = 0; c < NUM_CH; c++) begin : g_ch
        localparam int unsigned ROT = (4 * c) % 16;

        ch_state_e     state_q;
        ch_state_e     state_d;
        logic [BW-1:0] burst_q;
        logic [BW-1:0] burst_d;
        logic [7:0]    draw_byte;
        logic [6:0]    draw;
        logic          pending;

        // Each channel sees a different nibble rotation so channels decorrelate.
        assign draw_byte = 8'((lfsr_q >> ROT) | (lfsr_q << ((16 - ROT) % 16)));
        assign draw      = 7'((16'(draw_byte) * 16'd100) >> 8);
        assign pending   = valid_i[c] & ~ready_i[c];

        always_ff @(posedge clk_i or negedge rst_ni) begin
            if (!rst_ni) begin
                state_q <= ST_OPEN;
                burst_q <= '0;
            end else begin
                state_q <= state_d;
                burst_q <= burst_d;
            end
        end

        // A pending beat blocks the decision so valid_o is never withdrawn mid-beat.
        always_comb begin
            state_d = state_q;
            burst_d = burst_q;
            unique case (state_q)
                ST_OPEN: begin
                    if (!pending && cfg_en_i && (draw < level_clamped)) begin
                        state_d = ST_STALL;
                        burst_d = burst_load;
                    end
                end
                ST_STALL: begin
                    if (!cfg_en_i || (burst_q == BW'(1))) begin
                        state_d = ST_OPEN;
                        burst_d = '0;
                    end else begin
                        burst_d = burst_q - BW'(1);
                    end
                end
                default: begin
                    state_d = ST_OPEN;
                    burst_d = '0;
                end
            endcase
        end

        assign valid_o[c] = (state_q == ST_OPEN) & valid_i[c];
        assign ready_o[c] = (state_q == ST_OPEN) & ready_i[c];
        assign stalled[c] = (state_q == ST_STALL) & valid_i[c];
    end

    always_comb begin
        stall_pop = '0;
        for (int i = 0; i < NUM_CH; i++) begin
            stall_pop = stall_pop + PW'(stalled[i]);
        end
    end

    // Carry out of the 33-bit sum means the counter would wrap, so pin it instead.
    assign stall_sum   = {1'b0, stall_cnt_q} + 33'(stall_pop);
    assign stall_cnt_d = stall_sum[32] ? 32'hFFFF_FFFF : stall_sum[31:0];

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            stall_cnt_q <= '0;
        end else begin
            stall_cnt_q <= stall_cnt_d;
        end
    end

    assign stall_cnt_o = stall_cnt_q;

endmodule

// File: tb/tb_congestion_scheduler.sv
// Directed bench for congestion_scheduler: pass-through, burst duty, pending-beat
// protection, LFSR sequence, enable drop, reset and counter saturation.
module tb_congestion_scheduler;

    localparam int unsigned NUM_CH = 4;
    localparam int unsigned BW     = 4;

    logic              clk_i;
    logic              rst_ni;
    logic              cfg_en_i;
    logic [6:0]        cfg_level_i;
    logic [BW-1:0]     cfg_burst_i;
    logic [NUM_CH-1:0] valid_i;
    logic [NUM_CH-1:0] ready_o;
    logic [NUM_CH-1:0] valid_o;
    logic [NUM_CH-1:0] ready_i;
    logic [31:0]       stall_cnt_o;

    int checks = 0;
    int errors = 0;

    congestion_scheduler #(
        .NUM_CH   (NUM_CH),
        .SEED     (16'hACE1),
        .MAX_BURST(15)
    ) dut (
        .clk_i      (clk_i),
        .rst_ni     (rst_ni),
        .cfg_en_i   (cfg_en_i),
        .cfg_level_i(cfg_level_i),
        .cfg_burst_i(cfg_burst_i),
        .valid_i    (valid_i),
        .ready_o    (ready_o),
        .valid_o    (valid_o),
        .ready_i    (ready_i),
        .stall_cnt_o(stall_cnt_o)
    );

    initial clk_i = 1'b0;
    always #5 clk_i = ~clk_i;

    task automatic checkOutput(input string tag, input logic [31:0] observed,
                               input logic [31:0] expected);
        checks++;
        if (observed !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", tag, observed, expected);
        end
    endtask

    task automatic applyStimulus(input logic en, input logic [6:0] level,
                                 input logic [BW-1:0] burst,
                                 input logic [NUM_CH-1:0] v, input logic [NUM_CH-1:0] r);
        cfg_en_i    = en;
        cfg_level_i = level;
        cfg_burst_i = burst;
        valid_i     = v;
        ready_i     = r;
    endtask

    // Hold reset for a full cycle, then release on a falling edge so the next
    // rising edge is the first decision edge (LFSR still at SEED).
    task automatic startRun(input logic en, input logic [6:0] level,
                            input logic [BW-1:0] burst,
                            input logic [NUM_CH-1:0] v, input logic [NUM_CH-1:0] r);
        rst_ni = 1'b0;
        applyStimulus(en, level, burst, v, r);
        @(negedge clk_i);
        @(negedge clk_i);
        rst_ni = 1'b1;
    endtask

    initial begin
        int          mismatches;
        int          stall_count [NUM_CH];
        logic [31:0] sig_run [2];
        logic [7:0]  pat8;
        logic [3:0]  pat4;
        logic [3:0]  seq_exp [3];

        seq_exp[0] = 4'b0111;
        seq_exp[1] = 4'b1100;
        seq_exp[2] = 4'b1011;

        rst_ni = 1'b0;
        applyStimulus(1'b1, 7'd100, 4'd3, 4'hA, 4'h5);
        @(negedge clk_i);
        @(negedge clk_i);
        #1;
        checkOutput("rst_valid_passthru", 32'(valid_o), 32'h0000_000A);
        checkOutput("rst_ready_passthru", 32'(ready_o), 32'h0000_0005);
        checkOutput("rst_stall_cnt", stall_cnt_o, 32'h0);

        $display("[TB] level 0 pass-through");
        startRun(1'b1, 7'd0, 4'd3, 4'hF, 4'hF);
        mismatches = 0;
        for (int i = 0; i < 1000; i++) begin
            @(negedge clk_i);
            if (i >= 500) applyStimulus(1'b1, 7'd0, 4'd3, 4'(i), 4'(i >> 2));
            #1;
            if (valid_o !== valid_i || ready_o !== ready_i) mismatches++;
        end
        checkOutput("t1_passthru_mismatches", 32'(mismatches), 32'h0);
        checkOutput("t1_stall_cnt", stall_cnt_o, 32'h0);

        $display("[TB] level 100, burst 3 duty");
        startRun(1'b1, 7'd100, 4'd3, 4'h1, 4'h1);
        pat8 = 8'b1000_1000;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk_i);
            checkOutput($sformatf("t2_valid0_cyc%0d", i), 32'(valid_o[0]), 32'(pat8[i]));
        end
        repeat (392) @(negedge clk_i);
        checkOutput("t2_stall_cnt_400", stall_cnt_o, 32'd300);

        $display("[TB] burst 0 treated as 1");
        startRun(1'b1, 7'd100, 4'd0, 4'h1, 4'h1);
        pat4 = 4'b1010;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk_i);
            checkOutput($sformatf("t2b_valid0_cyc%0d", i), 32'(valid_o[0]), 32'(pat4[i]));
        end

        $display("[TB] pending beat blocks stall");
        startRun(1'b1, 7'd100, 4'd1, 4'h1, 4'h0);
        mismatches = 0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk_i);
            if (valid_o[0] !== 1'b1) mismatches++;
        end
        checkOutput("t3_held_valid", 32'(mismatches), 32'h0);
        ready_i = 4'h1;
        #1;
        checkOutput("t3_handshake_valid", 32'(valid_o[0]), 32'h1);
        checkOutput("t3_handshake_ready", 32'(ready_o[0]), 32'h1);
        @(negedge clk_i);
        checkOutput("t3_stall_after_accept", 32'(valid_o[0]), 32'h0);

        $display("[TB] level 50 LFSR sequence and statistics");
        for (int run = 0; run < 2; run++) begin
            startRun(1'b1, 7'd50, 4'd1, 4'hF, 4'hF);
            sig_run[run] = 32'h0;
            for (int c = 0; c < NUM_CH; c++) stall_count[c] = 0;
            for (int i = 0; i < 10000; i++) begin
                @(negedge clk_i);
                if (run == 0 && i < 3)
                    checkOutput($sformatf("t4_seq_cyc%0d", i), 32'(valid_o), 32'(seq_exp[i]));
                sig_run[run] = (sig_run[run] * 32'd33) ^ 32'(valid_o);
                for (int c = 0; c < NUM_CH; c++)
                    if (!valid_o[c]) stall_count[c]++;
            end
            if (run == 0) begin
                for (int c = 0; c < NUM_CH; c++)
                    checkOutput($sformatf("t4_frac_ch%0d_in_30_36pct", c),
                                32'(stall_count[c] >= 3000 && stall_count[c] <= 3600), 32'h1);
            end
        end
        checkOutput("t4_repeatable_trace", sig_run[1], sig_run[0]);

        $display("[TB] enable drop mid-burst");
        startRun(1'b1, 7'd100, 4'd8, 4'h1, 4'h1);
        @(negedge clk_i);
        @(negedge clk_i);
        checkOutput("t5_in_burst", 32'(valid_o[0]), 32'h0);
        cfg_en_i = 1'b0;
        @(negedge clk_i);
        checkOutput("t5_reopen", 32'(valid_o[0]), 32'h1);
        applyStimulus(1'b0, 7'd100, 4'd8, 4'hF, 4'hF);
        mismatches = 0;
        for (int i = 0; i < 30; i++) begin
            @(negedge clk_i);
            if (valid_o !== 4'hF) mismatches++;
        end
        checkOutput("t5_no_stall_disabled", 32'(mismatches), 32'h0);
        checkOutput("t5_stall_cnt", stall_cnt_o, 32'd2);

        $display("[TB] reset mid-burst");
        startRun(1'b1, 7'd100, 4'd8, 4'hF, 4'hF);
        repeat (5) @(negedge clk_i);
        checkOutput("t6_cnt_before_reset", stall_cnt_o, 32'd16);
        rst_ni = 1'b0;
        applyStimulus(1'b1, 7'd100, 4'd8, 4'h6, 4'h9);
        #1;
        checkOutput("t6_rst_valid", 32'(valid_o), 32'h6);
        checkOutput("t6_rst_ready", 32'(ready_o), 32'h9);
        checkOutput("t6_rst_cnt", stall_cnt_o, 32'h0);
        startRun(1'b1, 7'd50, 4'd1, 4'hF, 4'hF);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk_i);
            checkOutput($sformatf("t6_seq_restart_cyc%0d", i), 32'(valid_o), 32'(seq_exp[i]));
        end

        $display("[TB] counter saturation");
        startRun(1'b1, 7'd100, 4'd1, 4'hF, 4'hF);
        @(negedge clk_i);
        force dut.stall_cnt_q = 32'hFFFF_FFFA;
        #1;
        release dut.stall_cnt_q;
        @(negedge clk_i);
        checkOutput("t7_near_top", stall_cnt_o, 32'hFFFF_FFFE);
        @(negedge clk_i);
        @(negedge clk_i);
        checkOutput("t7_saturate", stall_cnt_o, 32'hFFFF_FFFF);
        repeat (4) @(negedge clk_i);
        checkOutput("t7_hold", stall_cnt_o, 32'hFFFF_FFFF);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
